// File: rtl/serial_ha_adder.sv
// serial_ha_adder: bit-serial adder, LSB first, one bit per clock.
// The bit cell is two half adders plus an OR on their carries.
module serial_ha_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic [CW-1:0]    count;
  logic             carry;
  logic             s1, c1, s, c2;
  logic             carry_nxt;
  logic             last;

  // {carry, sum}
  function automatic logic [1:0] ha(
    input logic x,
    input logic y
  );
    return {x & y, x ^ y};
  endfunction

  assign {c1, s1} = ha(a_sr[0], b_sr[0]);
  assign {c2, s}  = ha(s1, carry);
  assign carry_nxt = c1 | c2;
  assign r_nxt = {s, r_sr[WIDTH-1:1]};
  assign last = (count == CW'(WIDTH - 1));

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            r_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
          end
        end
        S_RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          r_sr  <= r_nxt;
          carry <= carry_nxt;
          count <= count + 1'b1;
          // Result registers only move on the final bit.
          if (last) begin
            sum_out <= r_nxt;
            cout    <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ha_adder.sv
// tb_serial_ha_adder: checks WIDTH=4 and WIDTH=8 instances against
// a cycle-timed arithmetic model of accept/complete events.
module tb_serial_ha_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  always #5 clk = ~clk;

  serial_ha_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4),
    .sum_out(sum4), .cout(cout4)
  );

  serial_ha_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8),
    .sum_out(sum8), .cout(cout8)
  );

  // Model: an accept at edge k completes at edge k+W, the
  // result is {cout,sum} = a+b, and the next accept is at k+W+2.
  int         cyc = 0;
  int         acc4 = -1000, acc8 = -1000;
  logic [4:0] res4 = '0, pend4 = '0;
  logic [8:0] res8 = '0, pend8 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc4 = -1000;
      acc8 = -1000;
      res4 = '0;
      res8 = '0;
    end else begin
      cyc = cyc + 1;
      if (cyc == acc4 + 4) res4 = pend4;
      if (cyc == acc8 + 8) res8 = pend8;
      if (start4 && cyc >= acc4 + 6) begin
        acc4  = cyc;
        pend4 = {1'b0, a4} + {1'b0, b4};
      end
      if (start8 && cyc >= acc8 + 10) begin
        acc8  = cyc;
        pend8 = {1'b0, a8} + {1'b0, b8};
      end
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int          lit_req = 0;
  int          lit_seen = 0;
  int          lit_w = 4;
  logic [16:0] lit_exp = '0;
  string       lit_nm = "";

  task automatic chk(
    input string       nm,
    input logic [16:0] act,
    input logic [16:0] exp
  );
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk or posedge rst);
    #1;
    chk("busy4", 17'(busy4),
        17'(cyc >= acc4 && cyc <= acc4 + 4));
    chk("done4", 17'(done4), 17'(cyc == acc4 + 4));
    chk("res4", 17'({cout4, sum4}), 17'(res4));
    chk("busy8", 17'(busy8),
        17'(cyc >= acc8 && cyc <= acc8 + 8));
    chk("done8", 17'(done8), 17'(cyc == acc8 + 8));
    chk("res8", 17'({cout8, sum8}), 17'(res8));
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      if (lit_w == 4) begin
        chk({lit_nm, "_dut"}, 17'({cout4, sum4}), lit_exp);
        chk({lit_nm, "_mdl"}, 17'(res4), lit_exp);
      end else begin
        chk({lit_nm, "_dut"}, 17'({cout8, sum8}), lit_exp);
        chk({lit_nm, "_mdl"}, 17'(res8), lit_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic lit(
    input int          w,
    input logic [16:0] e,
    input string       nm
  );
    lit_w   = w;
    lit_exp = e;
    lit_nm  = nm;
    lit_req = lit_req + 1;
  endtask

  task automatic add4(input logic [3:0] a, input logic [3:0] b);
    start4 = 1'b1;
    a4 = a;
    b4 = b;
    tick(1);
    start4 = 1'b0;
    a4 = ~a;
    b4 = ~b;
    tick(5);
  endtask

  task automatic add8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    tick(1);
    start8 = 1'b0;
    a8 = $urandom;
    b8 = $urandom;
    tick(9);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    lit(4, 17'd0, "reset4");
    tick(1);
    lit(8, 17'd0, "reset8");
    tick(1);

    add4(4'd5, 4'd3);
    lit(4, 17'h08, "5p3");
    add4(4'd15, 4'd1);
    lit(4, 17'h10, "15p1");
    add4(4'd15, 4'd15);
    lit(4, 17'h1e, "15p15");
    add4(4'd0, 4'd0);
    lit(4, 17'h00, "0p0");

    // start held high; operands disturbed outside accept edges
    start4 = 1'b1;
    a4 = 4'd9;
    b4 = 4'd6;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      a4 = 4'd3;
      b4 = 4'd3;
      tick(4);
      a4 = 4'd9;
      b4 = 4'd6;
      tick(2);
    end
    start4 = 1'b0;
    tick(6);
    lit(4, 17'h0f, "hold9p6");

    add4(4'd2, 4'd2);
    lit(4, 17'h04, "2p2");
    start4 = 1'b1;
    a4 = 4'd7;
    b4 = 4'd7;
    tick(1);
    start4 = 1'b0;
    tick(2);
    #1 rst = 1'b1;
    lit(4, 17'h00, "rst_clear");
    tick(1);
    rst = 1'b0;
    tick(8);
    add4(4'd1, 4'd1);
    lit(4, 17'h02, "1p1");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        add4(4'(a), 4'(b));
      end
    end

    add8(8'd255, 8'd1);
    lit(8, 17'h100, "255p1");
    add8(8'd128, 8'd128);
    lit(8, 17'h100, "128p128");
    add8(8'd100, 8'd27);
    lit(8, 17'h07f, "100p27");
    for (int i = 0; i < 1000; i++) begin
      add8(8'($urandom), 8'($urandom));
    end

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_ha_adder.md
Name: serial_ha_adder

Overview:
- Bit-serial N-bit adder stage sitting directly downstream of the HA half-adder cell. It consumes HA's Sum/Cout each cycle.
- The bit cell is a full adder built from two HA instances plus an OR on their carries. This stage adds the carry flip-flop, the operand/result shift registers, a bit counter and a start/done handshake.
- Turns the combinational half-adder into a multi-bit adder used by later lab datapaths (accumulators, counters).

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; honoured only in IDLE.
- a_in  input  WIDTH  operand A, sampled on the accepting edge only.
- b_in  input  WIDTH  operand B, sampled on the accepting edge only.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum_out  output  WIDTH  result of A+B mod 2^WIDTH; holds until the next completion.
- cout  output  1  carry out of the MSB; holds with sum_out.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - Operand registers, carry flip-flop, counter, sum_out and cout all cleared to 0.
  - busy=0, done=0.
  - Takes effect immediately, including mid-RUN. The in-flight addition is discarded and no done pulse follows.
- States: IDLE, RUN, DONE. State register and outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - On a rising edge with start=1: load a_in/b_in into shift registers A_sr/B_sr, clear carry and result shift register, set count=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, on each rising edge:
  - Bit cell inputs: A_sr[0], B_sr[0], carry_ff.
  - HA#1(A_sr[0], B_sr[0]) -> s1, c1.
  - HA#2(s1, carry_ff) -> s, c2.
  - carry_next = c1 | c2.
  - Result register shifts right with s entering at the MSB.
  - A_sr/B_sr shift right with 0 entering at the MSB.
  - carry_ff <= carry_next; count <= count+1.
  - When the edge processes bit WIDTH-1 (count==WIDTH-1 before the edge):
    - sum_out <= final shifted result.
    - cout <= carry_next.
    - Go to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency:
  - Accepting edge = E0.
  - Bits processed on edges E1..E_WIDTH.
  - sum_out/cout update on E_WIDTH; done is high between E_WIDTH and E_WIDTH+1.
  - Earliest next accept is E_WIDTH+2, so throughput is one addition per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored, with no queuing. a_in/b_in changes after E0 have no effect.
- sum_out/cout keep their last result through IDLE and the next RUN. They are overwritten only at the next completion edge.
- Counter width is clog2(WIDTH)+1 bits and never wraps within a run.
- cout=1 exactly when a_in+b_in >= 2^WIDTH.
- Unknown/X on start while in IDLE: no requirement. The bench must drive clean values.

Test Plan:
- WIDTH=4, a_in=5, b_in=3, start pulse one cycle -> busy rises after E0; done high in the cycle after E4; sum_out=8, cout=0.
- a_in=15, b_in=1 -> sum_out=0, cout=1. a_in=15, b_in=15 -> sum_out=14, cout=1. a_in=0, b_in=0 -> sum_out=0, cout=0. done=1 for exactly one cycle in each case.
- Hold start=1 continuously with a_in=9, b_in=6 -> results 15/0 are produced once every 6 cycles. Operand changes made mid-RUN do not affect the result; start asserted in RUN/DONE is ignored.
- Complete 2+2 (sum_out=4), then start 7+7 and assert rst asynchronously (between edges) after E2:
  - Immediately: busy=0, done=0, sum_out=0, cout=0.
  - No done pulse afterwards.
  - Next start with 1+1 gives sum_out=2.
- Exhaustive: all 256 (a_in,b_in) pairs at WIDTH=4, compared against the reference model {cout,sum_out}=a_in+b_in. Repeat with WIDTH=8 random 1000 pairs plus the corner cases 255+1 and 128+128.
